// File: rtl/ext_bus_bridge_if.sv
// CPU memory bus plus slow external req/ack bus seen by ext_bus_bridge.
// master: the CPU and external memory side; slave: the bridge itself.
interface ext_bus_bridge_if;
  // CPU side
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [3:0]  data_w_i;
  logic [2:0]  data_mode_i;
  logic [31:0] data_o;
  logic        stall_o;
  // External bus side
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;
  logic        mem_ack_i;

  modport master (
    output addr_i, data_i, data_w_i, data_mode_i, mem_data_i, mem_ack_i,
    input  data_o, stall_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_data_o
  );

  modport slave (
    input  addr_i, data_i, data_w_i, data_mode_i, mem_data_i, mem_ack_i,
    output data_o, stall_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/ext_bus_bridge.sv
// Decodes CPU accesses: on-chip RAM window passes through, external window
// becomes a stalled req/ack transfer with timeout and error reporting.
module ext_bus_bridge #(
  parameter logic [3:0]  EXT_BASE = 4'h6,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  ext_bus_bridge_if.slave    bus,
  input  logic [31:0]        ram_data_i,
  output logic               err_o,
  output logic [31:0]        err_addr_o,
  output logic [1:0]         state_o,
  output logic [4:0]         acc_info_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [31:0] word_q;
  logic        sel_ext_q;
  logic        req_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] err_addr_q;
  logic [4:0]  info_q;

  logic ext_hit;
  logic is_write;

  assign ext_hit  = (bus.addr_i[31:28] == EXT_BASE);
  assign is_write = |bus.data_w_i;

  // Handshake: mem_req_o acts as valid and mem_ack_i as ready. While mem_req_o
  // is high, address, write data, we and byte enables stay stable; the transfer
  // completes on the edge where mem_ack_i is seen high in REQ. Every transfer
  // passes through RESP, so two requests are always separated by an idle cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= 16'd0;
      word_q     <= 32'd0;
      sel_ext_q  <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      err_q      <= 1'b0;
      err_addr_q <= 32'd0;
      info_q     <= 5'd0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (ext_hit) begin
            addr_q  <= {bus.addr_i[31:2], 2'b00};
            wdata_q <= bus.data_i;
            we_q    <= is_write;
            be_q    <= is_write ? bus.data_w_i : 4'b1111;
            info_q  <= {bus.data_mode_i, bus.addr_i[1:0]};
            req_q   <= 1'b1;
            cnt_q   <= 16'd0;
            state_q <= REQ;
          end else begin
            sel_ext_q <= 1'b0;
          end
        end
        REQ: begin
          // An ack arriving on the timeout cycle still completes normally.
          if (bus.mem_ack_i) begin
            word_q    <= bus.mem_data_i;
            req_q     <= 1'b0;
            sel_ext_q <= 1'b1;
            state_q   <= RESP;
          end else if (cnt_q == CNT_LAST) begin
            word_q     <= ERR_DATA;
            req_q      <= 1'b0;
            err_q      <= 1'b1;
            err_addr_q <= addr_q;
            sel_ext_q  <= 1'b1;
            state_q    <= RESP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RESP: begin
          // The held CPU address is deliberately not decoded here.
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.stall_o    = (state_q == REQ) || ((state_q == IDLE) && ext_hit);
  assign bus.data_o     = sel_ext_q ? word_q : ram_data_i;
  assign bus.mem_req_o  = req_q;
  assign bus.mem_we_o   = we_q;
  assign bus.mem_be_o   = be_q;
  assign bus.mem_addr_o = addr_q;
  assign bus.mem_data_o = wdata_q;

  assign err_o      = err_q;
  assign err_addr_o = err_addr_q;
  assign state_o    = state_q;
  assign acc_info_o = info_q;

endmodule

// File: tb/tb_ext_bus_bridge.sv
// Directed bench for ext_bus_bridge with TIMEOUT=8 and hand-computed expectations.
module tb_ext_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ram_data;
  logic        err;
  logic [31:0] err_addr;
  logic [1:0]  state;
  logic [4:0]  info;

  int errors = 0;
  int checks = 0;

  ext_bus_bridge_if bus ();

  ext_bus_bridge #(
    .EXT_BASE(4'h6),
    .TIMEOUT (8),
    .ERR_DATA(32'hFFFF_FFFF)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus),
    .ram_data_i(ram_data),
    .err_o     (err),
    .err_addr_o(err_addr),
    .state_o   (state),
    .acc_info_o(info)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: starts an external access from IDLE (called just after an edge),
  // answers with ack in REQ cycle ack_at (0 = never), returns in the RESP cycle.
  task automatic run_ext(input logic [31:0] addr, input logic [3:0] w, input logic [31:0] wdata,
                         input logic [2:0] mode, input int ack_at, input logic [31:0] rdata,
                         output int req_n, output int stall_n, output logic stable,
                         output logic [31:0] f_addr, output logic [3:0] f_be,
                         output logic f_we, output logic [31:0] f_wdata, output logic hung);
    req_n   = 0;
    stall_n = 0;
    stable  = 1'b1;
    hung    = 1'b0;
    f_addr  = '0;
    f_be    = '0;
    f_we    = 1'b0;
    f_wdata = '0;
    bus.addr_i      = addr;
    bus.data_i      = wdata;
    bus.data_w_i    = w;
    bus.data_mode_i = mode;
    #1;
    if (bus.stall_o) stall_n++;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (!bus.mem_req_o) break;
      req_n++;
      if (bus.stall_o) stall_n++;
      if (req_n == 1) begin
        f_addr  = bus.mem_addr_o;
        f_be    = bus.mem_be_o;
        f_we    = bus.mem_we_o;
        f_wdata = bus.mem_data_o;
        bus.data_i = ~wdata;
      end else if (bus.mem_addr_o !== f_addr || bus.mem_be_o !== f_be ||
                   bus.mem_we_o !== f_we || bus.mem_data_o !== f_wdata) begin
        stable = 1'b0;
      end
      if (req_n == ack_at) begin
        bus.mem_ack_i  = 1'b1;
        bus.mem_data_i = rdata;
      end
      if (c == 99) hung = 1'b1;
    end
    bus.mem_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    bus.addr_i      = 32'h4000_0000;
    bus.data_i      = 32'd0;
    bus.data_w_i    = 4'd0;
    bus.data_mode_i = 3'd0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_data_i  = 32'd0;
    ram_data        = 32'h1111_1111;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", bus.mem_req_o); end
    checks++; if (bus.mem_be_o !== 4'd0 || bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL reset_be_we: got be=%h we=%b expected 0/0", bus.mem_be_o, bus.mem_we_o); end
    checks++; if (bus.mem_addr_o !== 32'd0 || bus.mem_data_o !== 32'd0) begin errors++; $display("FAIL reset_addr_data: got %h/%h expected 0/0", bus.mem_addr_o, bus.mem_data_o); end
    checks++; if (err !== 1'b0 || err_addr !== 32'd0) begin errors++; $display("FAIL reset_err: got %b/%h expected 0/0", err, err_addr); end
    checks++; if (state !== 2'd0 || bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_state: got state=%0d stall=%b expected 0/0", state, bus.stall_o); end
    checks++; if (bus.data_o !== 32'h1111_1111) begin errors++; $display("FAIL reset_data_sel: got %h expected 11111111", bus.data_o); end
  endtask

  task automatic test_fast_read();
    bus.addr_i = 32'h4000_0010;
    ram_data   = 32'hCAFE_BABE;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.stall_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL fast_read_stall: got stall=%b req=%b expected 0/0", bus.stall_o, bus.mem_req_o); end
      checks++; if (bus.data_o !== 32'hCAFE_BABE) begin errors++; $display("FAIL fast_read_data: got %h expected cafebabe", bus.data_o); end
    end
  endtask

  task automatic test_ext_read();
    int rn, sn;
    logic st, fwe, hung;
    logic [31:0] fa, fd;
    logic [3:0] fbe;
    ram_data = 32'h0BAD_F00D;
    run_ext(32'h6000_0104, 4'd0, 32'd0, 3'b001, 3, 32'h1234_5678, rn, sn, st, fa, fbe, fwe, fd, hung);
    checks++; if (hung !== 1'b0 || rn != 3) begin errors++; $display("FAIL ext_read_req_cycles: got %0d expected 3", rn); end
    checks++; if (sn != 4) begin errors++; $display("FAIL ext_read_stall_cycles: got %0d expected 4", sn); end
    checks++; if (fa !== 32'h6000_0104 || fbe !== 4'hF || fwe !== 1'b0) begin errors++; $display("FAIL ext_read_req_fields: got %h/%h/%b expected 60000104/f/0", fa, fbe, fwe); end
    checks++; if (bus.data_o !== 32'h1234_5678 || state !== 2'd2) begin errors++; $display("FAIL ext_read_resp: got %h state=%0d expected 12345678 state=2", bus.data_o, state); end
    bus.addr_i = 32'h4000_0000;
    #1;
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL ext_read_resp_stall: got %b expected 0", bus.stall_o); end
    tick();
    checks++; if (bus.data_o !== 32'h1234_5678) begin errors++; $display("FAIL ext_read_hold: got %h expected 12345678", bus.data_o); end
    tick();
    checks++; if (bus.data_o !== 32'h0BAD_F00D || bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL ext_read_back_to_ram: got %h req=%b expected 0badf00d req=0", bus.data_o, bus.mem_req_o); end
  endtask

  task automatic test_ext_write();
    int rn, sn;
    logic st, fwe, hung;
    logic [31:0] fa, fd;
    logic [3:0] fbe;
    run_ext(32'h6000_0203, 4'b1000, 32'hAB00_0000, 3'b101, 4, 32'h0, rn, sn, st, fa, fbe, fwe, fd, hung);
    checks++; if (fwe !== 1'b1 || fbe !== 4'b1000) begin errors++; $display("FAIL ext_write_we_be: got %b/%h expected 1/8", fwe, fbe); end
    checks++; if (fa !== 32'h6000_0200 || fd !== 32'hAB00_0000) begin errors++; $display("FAIL ext_write_addr_data: got %h/%h expected 60000200/ab000000", fa, fd); end
    checks++; if (st !== 1'b1 || rn != 4 || hung !== 1'b0) begin errors++; $display("FAIL ext_write_stable: got stable=%b cycles=%0d expected 1/4", st, rn); end
    checks++; if (info !== 5'b10111) begin errors++; $display("FAIL ext_write_info: got %b expected 10111", info); end
    checks++; if (bus.mem_req_o !== 1'b0 || bus.stall_o !== 1'b0) begin errors++; $display("FAIL ext_write_resp: got req=%b stall=%b expected 0/0", bus.mem_req_o, bus.stall_o); end
    bus.addr_i   = 32'h4000_0000;
    bus.data_w_i = 4'd0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    int rn, sn;
    logic st, fwe, hung;
    logic [31:0] fa, fd;
    logic [3:0] fbe;
    run_ext(32'h6000_0AB0, 4'd0, 32'd0, 3'b001, 0, 32'h0, rn, sn, st, fa, fbe, fwe, fd, hung);
    checks++; if (rn != 8 || hung !== 1'b0) begin errors++; $display("FAIL timeout_req_cycles: got %0d expected 8", rn); end
    checks++; if (err !== 1'b1 || err_addr !== 32'h6000_0AB0) begin errors++; $display("FAIL timeout_err: got %b/%h expected 1/60000ab0", err, err_addr); end
    checks++; if (bus.data_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL timeout_data: got %h expected ffffffff", bus.data_o); end
    bus.addr_i = 32'h4000_0000;
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL timeout_pulse_len: got %b expected 0", err); end
    run_ext(32'h6000_0C00, 4'd0, 32'd0, 3'b001, 8, 32'h5A5A_5A5A, rn, sn, st, fa, fbe, fwe, fd, hung);
    checks++; if (rn != 8 || err !== 1'b0) begin errors++; $display("FAIL timeout_ack_wins: got cycles=%0d err=%b expected 8/0", rn, err); end
    checks++; if (bus.data_o !== 32'h5A5A_5A5A || err_addr !== 32'h6000_0AB0) begin errors++; $display("FAIL timeout_ack_data: got %h/%h expected 5a5a5a5a/60000ab0", bus.data_o, err_addr); end
    bus.addr_i = 32'h4000_0000;
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL timeout_ack_no_err: got %b expected 0", err); end
  endtask

  task automatic test_reset_in_req();
    ram_data   = 32'h7777_7777;
    bus.addr_i = 32'h6000_0300;
    tick();
    checks++; if (bus.mem_req_o !== 1'b1 || state !== 2'd1) begin errors++; $display("FAIL rst_req_setup: got req=%b state=%0d expected 1/1", bus.mem_req_o, state); end
    rst        = 1'b1;
    bus.addr_i = 32'h4000_0000;
    tick();
    rst = 1'b0;
    checks++; if (bus.mem_req_o !== 1'b0 || bus.stall_o !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL rst_in_req: got req=%b stall=%b state=%0d expected 0/0/0", bus.mem_req_o, bus.stall_o, state); end
    bus.mem_ack_i  = 1'b1;
    bus.mem_data_i = 32'h0000_DEAD;
    tick();
    tick();
    bus.mem_ack_i = 1'b0;
    checks++; if (state !== 2'd0 || bus.mem_req_o !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_late_ack: got state=%0d req=%b err=%b expected 0/0/0", state, bus.mem_req_o, err); end
    checks++; if (bus.data_o !== 32'h7777_7777) begin errors++; $display("FAIL rst_late_ack_data: got %h expected 77777777", bus.data_o); end
  endtask

  task automatic test_back_to_back();
    int rn, sn;
    logic st, fwe, hung;
    logic [31:0] fa, fd;
    logic [3:0] fbe;
    run_ext(32'h6000_0010, 4'd0, 32'd0, 3'b001, 1, 32'hAAAA_0001, rn, sn, st, fa, fbe, fwe, fd, hung);
    checks++; if (sn != 2 || rn != 1) begin errors++; $display("FAIL b2b_first_latency: got stall=%0d req=%0d expected 2/1", sn, rn); end
    checks++; if (bus.data_o !== 32'hAAAA_0001) begin errors++; $display("FAIL b2b_first_data: got %h expected aaaa0001", bus.data_o); end
    bus.addr_i = 32'h6000_0020;
    #1;
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL b2b_resp_no_decode: got %b expected 0", bus.stall_o); end
    tick();
    checks++; if (bus.mem_req_o !== 1'b0 || bus.stall_o !== 1'b1 || state !== 2'd0) begin errors++; $display("FAIL b2b_idle_gap: got req=%b stall=%b state=%0d expected 0/1/0", bus.mem_req_o, bus.stall_o, state); end
    run_ext(32'h6000_0020, 4'd0, 32'd0, 3'b001, 2, 32'hBBBB_0002, rn, sn, st, fa, fbe, fwe, fd, hung);
    checks++; if (fa !== 32'h6000_0020 || rn != 2) begin errors++; $display("FAIL b2b_second_req: got %h cycles=%0d expected 60000020/2", fa, rn); end
    checks++; if (bus.data_o !== 32'hBBBB_0002) begin errors++; $display("FAIL b2b_second_data: got %h expected bbbb0002", bus.data_o); end
    bus.addr_i = 32'h4000_0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_fast_read();
    test_ext_read();
    test_ext_write();
    test_timeout();
    test_reset_in_req();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ext_bus_bridge.md
Name: ext_bus_bridge

Overview:
Sits directly downstream of the processor top-level and consumes its memory bus (address, write data, byte-enables, access mode). Decodes each access. Accesses to the on-chip RAM window pass straight through with zero wait states. Accesses to the external window become a req/ack handshake on a slow external bus, with the CPU stalled via stall_o until the transfer completes or times out.

Parameters:
EXT_BASE, 4'h6, addr_i[31:28] value selecting the external region
TIMEOUT, 255, max cycles mem_req_o waits for mem_ack_i before abort (1..65535)
ERR_DATA, 32'hFFFFFFFF, read data returned on timeout

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
addr_i  in  32  CPU address (fetch or data)
data_i  in  32  CPU write data
data_w_i  in  4  CPU byte write enables; nonzero = write
data_mode_i  in  3  {byte, half, data_access} from CPU
data_o  out  32  read data to CPU
stall_o  out  1  stall request to CPU
ram_data_i  in  32  on-chip RAM read data (synchronous, 1-cycle)
mem_req_o  out  1  external request
mem_we_o  out  1  external write
mem_be_o  out  4  external byte enables
mem_addr_o  out  32  external word address (bits 1:0 = 0)
mem_data_o  out  32  external write data
mem_data_i  in  32  external read data
mem_ack_i  in  1  external acknowledge
err_o  out  1  one-cycle pulse on timeout
err_addr_o  out  32  address of last timed-out access

Behaviour:
- ext_hit = (addr_i[31:28] == EXT_BASE). Combinational, evaluated every cycle.
- Reset (sync, rst_i high at a clock edge):
  - state=IDLE; mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_data_o=0.
  - err_o=0, err_addr_o=0, timeout counter=0, captured word=0, data_sel=RAM.
  - Reset mid-transfer drops mem_req_o on the next edge. Any late mem_ack_i in IDLE is ignored.
- States: IDLE, REQ, RESP.
- IDLE:
  - If !ext_hit: stall_o=0; data_sel registered to RAM. data_o = ram_data_i in the following cycle.
  - If ext_hit: stall_o=1 combinationally. On the edge: latch mem_addr_o={addr_i[31:2],2'b00}, mem_data_o=data_i, mem_we_o=|data_w_i, mem_be_o=(|data_w_i)?data_w_i:4'b1111. Set mem_req_o=1, clear counter, go to REQ.
- REQ: stall_o=1; mem_req_o, mem_addr_o, mem_we_o, mem_be_o and mem_data_o held stable.
  - mem_ack_i=1: capture mem_data_i (reads), drop mem_req_o, go to RESP.
  - Counter reaches TIMEOUT-1 without ack: capture ERR_DATA, drop mem_req_o, err_o=1 for one cycle, err_addr_o=mem_addr_o, go to RESP.
  - Ack and timeout in the same cycle: ack wins, no error.
- RESP (exactly one cycle):
  - stall_o=0; data_sel=EXT; data_o = captured word.
  - Return to IDLE. The CPU's held address is not re-decoded in this cycle, so the same access is not issued twice.
- data_o: mux of ram_data_i and the captured word, selected by the registered data_sel. After RESP the captured word is held until data_sel changes.
- Latency: external access = 1 (IDLE) + N ack cycles + 1 (RESP). Ack in the first REQ cycle gives 2 stall cycles.
- Handshake: mem_ack_i is only sampled in REQ. mem_req_o never goes high for two back-to-back accesses without passing through RESP, so there is at least one idle cycle between requests.
- data_mode_i is informational; sub-word reads fetch the full word and the CPU extracts lanes.
- Counter width is 16 bits; no wrap is possible because TIMEOUT ≤ 65535.

Test Plan:
- Fast read: addr_i=0x40000010, ram_data_i=0xCAFEBABE -> stall_o never high; data_o=0xCAFEBABE next cycle; mem_req_o stays 0.
- Ext read, ack after 3 cycles: addr_i=0x60000104, mem_data_i=0x12345678 -> mem_req_o high 3 cycles, mem_addr_o=0x60000104, mem_be_o=4'hF, stall_o high 4 cycles; data_o=0x12345678 in RESP.
- Ext byte write: addr_i=0x60000203, data_w_i=4'b1000, data_i=0xAB000000 -> mem_we_o=1, mem_be_o=4'b1000, mem_addr_o=0x60000200, mem_data_o=0xAB000000 stable until ack.
- Timeout, TIMEOUT=8, no ack -> mem_req_o drops after 8 cycles; err_o pulses once; err_addr_o=access address; data_o=0xFFFFFFFF; ack on the timeout cycle -> no err_o.
- Reset in REQ: rst_i high for 1 cycle -> mem_req_o=0 and stall_o=0 next cycle; a subsequent mem_ack_i while IDLE causes no state change.
- Back-to-back ext accesses: two ext addresses consecutively -> second mem_req_o rises only after the RESP cycle; each returns its own data.
